// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding,
// default operand width and the divide-by-zero quotient.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 16;

  // Sliced down to WIDTH at the point of use, so WIDTH must not exceed MAX_WIDTH.
  localparam int                   MAX_WIDTH     = 64;
  localparam logic [MAX_WIDTH-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step, purely combinational (zero latency, no flow control).
// Quotient bits enter the LSB of the dividend word as its MSB is shifted out.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] dvd_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] dvd_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           fits;

  always_comb begin
    shifted = {rem_i, dvd_i[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_i};
    // With rem_i < dvs_i, shifted < 2*dvs_i, so the MSB of the (WIDTH+1)-bit
    // difference is exactly the borrow.
    fits    = ~trial[WIDTH];
    rem_o   = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    dvd_o   = {dvd_i[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned divider: WIDTH-cycle restoring loop. Done pulses in cycle WIDTH+1 (cycle 1 on /0).
// Backpressure: Ready is high only in IDLE; Start is ignored while busy.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  output logic             Ready,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Done,
  output logic             DivZero
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             divzero_q, divzero_d;

  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_dvd;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .dvd_i (dvd_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .dvd_o (step_dvd)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    divzero_d   = divzero_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          if (OperandB == '0) begin
            state_d     = S_DONE;
            quotient_d  = DIV0_QUOTIENT[WIDTH-1:0];
            remainder_d = OperandA;
            divzero_d   = 1'b1;
          end else begin
            state_d = S_RUN;
            rem_d   = '0;
            dvd_d   = OperandA;
            dvs_d   = OperandB;
            cnt_d   = CW'(WIDTH);
          end
        end
      end
      S_RUN: begin
        rem_d = step_rem;
        dvd_d = step_dvd;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d     = S_DONE;
          quotient_d  = step_dvd;
          remainder_d = step_rem;
          divzero_d   = 1'b0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      divzero_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      divzero_q   <= divzero_d;
    end
  end

  assign Ready     = (state_q == S_IDLE);
  assign Done      = (state_q == S_DONE);
  assign Quotient  = quotient_q;
  assign Remainder = remainder_q;
  assign DivZero   = divzero_q;

endmodule
